fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue entry count; legal values are powers of two, 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start_i  input  1  SHALL enable issue of new fetch requests while high.
REQ-006 stall_i  input  1  SHALL be high when the IF/ID stage cannot accept an instruction this cycle.
REQ-007 flush_i  input  1  SHALL request redirect of fetch to flush_pc_i and discard of all queued instructions.
REQ-008 flush_pc_i  input  32  SHALL be the redirect target, sampled when flush_i is high.
REQ-009 imem_req_o  output  1  SHALL be the instruction-memory request.
REQ-010 imem_addr_o  output  32  SHALL be the instruction-memory word address.
REQ-011 imem_ack_i  input  1  SHALL mark imem_data_i valid for the outstanding request.
REQ-012 imem_data_i  input  32  SHALL be the returned instruction word.
REQ-013 valid_o  output  1  SHALL be high when instr_o/pc_o hold a valid instruction for IF/ID.
REQ-014 instr_o  output  32  SHALL be the head instruction; 32'h0000_0013 (NOP) when valid_o is low.
REQ-015 pc_o  output  32  SHALL be the head instruction's address; 0 when valid_o is low.

Function
REQ-016 The FSM SHALL have three states: IDLE (no request outstanding), REQ (request outstanding), DROP (outstanding request to be discarded).
REQ-017 IDLE->REQ SHALL occur when start_i is high, flush_i is low, and count < DEPTH; imem_req_o goes high with imem_addr_o = fetch_pc on the next cycle.
REQ-018 In REQ and DROP, imem_req_o SHALL stay high and imem_addr_o SHALL stay stable until the cycle imem_ack_i is high.
REQ-019 At most one request SHALL be outstanding; imem_req_o SHALL be low in IDLE.
REQ-020 REQ with imem_ack_i high and flush_i low SHALL push {fetch_pc, imem_data_i} into the queue, advance fetch_pc by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), and return to IDLE.
REQ-021 Space check SHALL use count plus the outstanding request; issue is refused when the response could overflow the queue.
REQ-022 A pop SHALL occur on a rising edge where valid_o is high, stall_i is low and flush_i is low.
REQ-023 A simultaneous push and pop SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Stall SHALL not stop fetching; requests continue until the queue is full.
REQ-025 flush_i high SHALL on that edge empty the queue (count = 0), load fetch_pc with flush_pc_i, and override any same-cycle pop.
REQ-026 A flush in REQ without same-cycle imem_ack_i SHALL move to DROP; a flush in REQ with same-cycle imem_ack_i SHALL discard the data and move to IDLE.
REQ-027 DROP SHALL discard the acknowledged data and move to IDLE on imem_ack_i; a further flush in DROP SHALL only update fetch_pc.
REQ-028 start_i low SHALL block new issue only; an outstanding request completes and the queue keeps draining.
REQ-029 valid_o SHALL equal (count != 0) in the base build; queue-to-output latency is one cycle after the push edge.

Reset
REQ-030 While rst_i is high: state = IDLE, count = 0, pointers = 0, fetch_pc = RESET_PC, imem_req_o = 0, imem_addr_o = RESET_PC, valid_o = 0, instr_o = NOP, pc_o = 0.
REQ-031 Reset asserted mid-request SHALL abandon the request; an imem_ack_i arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-032 Macro FETCH_BYPASS_EN defined: when count == 0, state is REQ, imem_ack_i is high and flush_i is low, valid_o/instr_o/pc_o SHALL present imem_data_i/fetch_pc combinationally in the same cycle. If stall_i is also low, the word SHALL be consumed without entering the queue; if stall_i is high, it SHALL be pushed.
REQ-033 Macro FETCH_BYPASS_EN undefined: no combinational path from imem_* to valid_o/instr_o/pc_o; behaviour per REQ-029.

Verification
REQ-034 Reset release, start_i=1, memory acks 1 cycle after each request, stall_i=0 -> addresses 0,4,8 issued in order; pc_o/instr_o sequence matches memory contents; no NOP gaps after the first instruction except request turnaround.
REQ-035 stall_i=1 held for 20 cycles with DEPTH=4 -> exactly 4 pushes, imem_req_o low afterwards, count=4; releasing stall -> pops of pc 0,4,8,12 on consecutive cycles.
REQ-036 flush_i=1, flush_pc_i=32'h0000_0100 while a request to 0x10 is outstanding, ack 3 cycles later -> 0x10 data dropped, next request address 0x100, valid_o low until 0x100 is returned.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
REQ-038 Push and pop on the same edge at count=2 -> count stays 2; pointer wrap exercised over 3*DEPTH instructions with no reordering.
REQ-039 FETCH_BYPASS_EN defined, empty queue, ack of 32'h0010_0093 at pc 0 with stall_i=0 -> valid_o=1 and instr_o=32'h0010_0093 in the ack cycle, count stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - single-outstanding instruction fetch FSM feeding a DEPTH-entry queue
// Optional same-cycle bypass of an empty queue: define FETCH_BYPASS_EN.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_addr;
   logic [AW:0]   r_count;
   logic [AW-1:0] r_wptr, r_rptr;
   logic [31:0]   r_pc_mem    [DEPTH];
   logic [31:0]   r_instr_mem [DEPTH];

   logic w_issue, w_ack_keep, w_bypass, w_push, w_pop;

   // Only one request can be in flight, so IDLE needs no allowance for it.
   assign w_issue    = (r_state == S_IDLE) && start_i && !flush_i && (r_count < FULL);
   assign w_ack_keep = (r_state == S_REQ) && imem_ack_i && !flush_i;
`ifdef FETCH_BYPASS_EN
   assign w_bypass   = w_ack_keep && (r_count == '0) && !stall_i;
`else
   assign w_bypass   = 1'b0;
`endif
   assign w_push     = w_ack_keep && !w_bypass;
   assign w_pop      = (r_count != '0) && !stall_i && !flush_i;
   assign imem_addr_o = r_addr;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      imem_req_o  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_issue) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            imem_req_o = 1'b1;
            if (imem_ack_i)   w_state_nxt = S_IDLE;
            else if (flush_i) w_state_nxt = S_DROP;
         end
         S_DROP: begin
            imem_req_o = 1'b1;
            if (imem_ack_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fetch_pc <= RESET_PC;
         r_addr     <= RESET_PC;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         if (w_issue) r_addr <= r_fetch_pc;

         if (flush_i)         r_fetch_pc <= flush_pc_i;
         else if (w_ack_keep) r_fetch_pc <= r_fetch_pc + 32'd4;

         // Flush wins over any same-edge push or pop.
         if (flush_i) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_pc_mem[r_wptr]    <= r_fetch_pc;
         r_instr_mem[r_wptr] <= imem_data_i;
      end
   end

   always_comb begin
      valid_o = 1'b0;
      instr_o = NOP;
      pc_o    = '0;
      if (r_count != '0) begin
         valid_o = 1'b1;
         instr_o = r_instr_mem[r_rptr];
         pc_o    = r_pc_mem[r_rptr];
      end
`ifdef FETCH_BYPASS_EN
      else if (w_ack_keep) begin
         valid_o = 1'b1;
         instr_o = imem_data_i;
         pc_o    = r_fetch_pc;
      end
`endif
   end

endmodule
